// File: rtl/pi_feedback_scaler.sv
// pi_feedback_scaler
// Programmable feedback gain stage between the PI controller output and the
// drive/DAC path. Each signed sample is arithmetically right-shifted by a
// run-time shift value, saturated to OUT_W bits, and forwarded with its
// channel tag through a 2-stage valid/ready pipeline.
//
// Build option: define FEEDBACK_ROUND_EN to add 2^(s-1) before shifting
// (round half toward +inf). Without it the shift floors toward -inf, which
// matches the legacy fixed shift-by-6 path.
//
// Stage 1 register holds the shifted value (IN_W+1 bits, so the rounding
// add can never overflow). Stage 2 is the output register and applies the
// saturation, which is also where the per-channel sticky flags are raised.

module pi_feedback_scaler #(
  parameter int IN_W      = 32,
  parameter int OUT_W     = 32,
  parameter int SHIFT_W   = 5,
  parameter int N_CH      = 2,
  parameter int CH_W      = (N_CH > 1) ? $clog2(N_CH) : 1,
  parameter int RST_SHIFT = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [CH_W-1:0]    in_ch,
  input  logic [IN_W-1:0]    feedback_i,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [CH_W-1:0]    out_ch,
  output logic [OUT_W-1:0]   feedback_o,
  input  logic               cfg_we,
  input  logic [SHIFT_W-1:0] cfg_shift,
  output logic [SHIFT_W-1:0] shift_o,
  input  logic               sat_clr,
  output logic [N_CH-1:0]    sat_flag
);

  // Saturation bounds expressed at the stage-1 width (IN_W+1 bits, signed).
  localparam logic signed [IN_W:0] MAX_V =
    {{(IN_W - OUT_W + 2){1'b0}}, {(OUT_W - 1){1'b1}}};
  localparam logic signed [IN_W:0] MIN_V =
    {{(IN_W - OUT_W + 2){1'b1}}, {(OUT_W - 1){1'b0}}};
  localparam logic [SHIFT_W-1:0] SHIFT_MAX  = SHIFT_W'(IN_W - 1);
  localparam logic [SHIFT_W-1:0] SHIFT_INIT = SHIFT_W'(RST_SHIFT);

  // ------------------------------------------------------------------
  // State
  // ------------------------------------------------------------------
  logic [SHIFT_W-1:0]    shift_q,      shift_d;
  logic                  s1_valid_q,   s1_valid_d;
  logic signed [IN_W:0]  s1_data_q,    s1_data_d;
  logic [CH_W-1:0]       s1_ch_q,      s1_ch_d;
  logic                  out_valid_q,  out_valid_d;
  logic [OUT_W-1:0]      feedback_q,   feedback_d;
  logic [CH_W-1:0]       out_ch_q,     out_ch_d;
  logic [N_CH-1:0]       sat_flag_q,   sat_flag_d;

  // Handshake and datapath intermediates
  logic                  s2_load;
  logic                  s1_load;
  logic                  accept;
  logic signed [IN_W:0]  ext;
  logic signed [IN_W:0]  rnd;
  logic signed [IN_W:0]  biased;
  logic signed [IN_W:0]  scaled;
  logic                  sat_hi;
  logic                  sat_lo;
  logic [OUT_W-1:0]      sat_value;
  logic                  sat_evt;

  // Pipeline flow control: stage 2 loads when empty or drained, stage 1
  // whenever it is empty or its content moves on to stage 2.
  always_comb begin
    s2_load = !out_valid_q || out_ready;
    s1_load = !s1_valid_q || s2_load;
    accept  = in_valid && s1_load;
  end

  assign in_ready = s1_load;

  // Gain-shift register next value; out-of-range shifts are clamped so the
  // datapath never sees a shift wider than the sample.
  always_comb begin
    shift_d = shift_q;
    if (cfg_we) begin
      if (int'(cfg_shift) >= IN_W) begin
        shift_d = SHIFT_MAX;
      end else begin
        shift_d = cfg_shift;
      end
    end
  end

  // Stage-1 arithmetic: sign-extend, optional rounding bias, arithmetic shift
  // by the shift value active at acceptance time.
  always_comb begin
    ext = {feedback_i[IN_W-1], feedback_i};
`ifdef FEEDBACK_ROUND_EN
    if (shift_q == '0) begin
      rnd = '0;
    end else begin
      rnd = {{IN_W{1'b0}}, 1'b1} << (shift_q - 1'b1);
    end
`else
    rnd = '0;
`endif
    biased = ext + rnd;
    scaled = biased >>> shift_q;
  end

  // Stage-1 register next values: capture a new sample only on acceptance.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_data_d  = s1_data_q;
    s1_ch_d    = s1_ch_q;
    if (s1_load) begin
      s1_valid_d = accept;
    end
    if (accept) begin
      s1_data_d = scaled;
      s1_ch_d   = in_ch;
    end
  end

  // Stage-2 saturation: clamp anything outside the OUT_W signed range,
  // otherwise the low OUT_W bits already carry the exact value.
  always_comb begin
    sat_hi = (s1_data_q > MAX_V);
    sat_lo = (s1_data_q < MIN_V);
    if (sat_hi) begin
      sat_value = MAX_V[OUT_W-1:0];
    end else if (sat_lo) begin
      sat_value = MIN_V[OUT_W-1:0];
    end else begin
      sat_value = s1_data_q[OUT_W-1:0];
    end
    sat_evt = s2_load && s1_valid_q && (sat_hi || sat_lo);
  end

  // Output register next values: hold while stalled so downstream sees a
  // stable sample until it is taken.
  always_comb begin
    out_valid_d = out_valid_q;
    feedback_d  = feedback_q;
    out_ch_d    = out_ch_q;
    if (s2_load) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        feedback_d = sat_value;
        out_ch_d   = s1_ch_q;
      end
    end
  end

  // Sticky saturation flags: a new event beats a simultaneous clear, and a
  // tag outside the channel range simply matches no flag bit.
  always_comb begin
    sat_flag_d = sat_clr ? '0 : sat_flag_q;
    for (int i = 0; i < N_CH; i++) begin
      if (sat_evt && (s1_ch_q == CH_W'(i))) begin
        sat_flag_d[i] = 1'b1;
      end
    end
  end

  // All state registers; reset empties the pipeline and restores the shift.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q     <= SHIFT_INIT;
      s1_valid_q  <= 1'b0;
      s1_data_q   <= '0;
      s1_ch_q     <= '0;
      out_valid_q <= 1'b0;
      feedback_q  <= '0;
      out_ch_q    <= '0;
      sat_flag_q  <= '0;
    end else begin
      shift_q     <= shift_d;
      s1_valid_q  <= s1_valid_d;
      s1_data_q   <= s1_data_d;
      s1_ch_q     <= s1_ch_d;
      out_valid_q <= out_valid_d;
      feedback_q  <= feedback_d;
      out_ch_q    <= out_ch_d;
      sat_flag_q  <= sat_flag_d;
    end
  end

  assign shift_o    = shift_q;
  assign out_valid  = out_valid_q;
  assign feedback_o = feedback_q;
  assign out_ch     = out_ch_q;
  assign sat_flag   = sat_flag_q;

endmodule

// File: tb/tb_pi_feedback_scaler.sv
// Testbench for pi_feedback_scaler (IN_W=32, OUT_W=16, SHIFT_W=6, N_CH=2).
// Directed scenarios followed by a randomized phase; every output
// transaction is compared against an arithmetic reference model.
module tb_pi_feedback_scaler;
  localparam int IN_W    = 32;
  localparam int OUT_W   = 16;
  localparam int SHIFT_W = 6;
  localparam int N_CH    = 2;
  localparam int CH_W    = 1;
  localparam int RST_SH  = 6;
  localparam longint OUT_MAX = (longint'(1) <<< (OUT_W - 1)) - 1;
  localparam longint OUT_MIN = -(longint'(1) <<< (OUT_W - 1));

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic [CH_W-1:0]    in_ch = '0;
  logic [IN_W-1:0]    feedback_i = '0;
  logic               out_valid;
  logic               out_ready = 1'b1;
  logic [CH_W-1:0]    out_ch;
  logic [OUT_W-1:0]   feedback_o;
  logic               cfg_we = 1'b0;
  logic [SHIFT_W-1:0] cfg_shift = '0;
  logic [SHIFT_W-1:0] shift_o;
  logic               sat_clr = 1'b0;
  logic [N_CH-1:0]    sat_flag;

  int n_checks = 0;
  int n_fail   = 0;

  longint exp_val_q[$];
  int     exp_ch_q[$];
  int     model_shift = RST_SH;

  pi_feedback_scaler #(
    .IN_W(IN_W), .OUT_W(OUT_W), .SHIFT_W(SHIFT_W), .N_CH(N_CH),
    .CH_W(CH_W), .RST_SHIFT(RST_SH)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_ch(in_ch),
    .feedback_i(feedback_i),
    .out_valid(out_valid), .out_ready(out_ready), .out_ch(out_ch),
    .feedback_o(feedback_o),
    .cfg_we(cfg_we), .cfg_shift(cfg_shift), .shift_o(shift_o),
    .sat_clr(sat_clr), .sat_flag(sat_flag)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: value / 2^s, floored (or rounded half up), then clamped.
  function automatic longint model_out(input logic [31:0] x, input int s);
    longint v;
    v = longint'($signed(x));
`ifdef FEEDBACK_ROUND_EN
    if (s > 0) v = v + (longint'(1) <<< (s - 1));
`endif
    v = v >>> s;
    if (v > OUT_MAX) v = OUT_MAX;
    else if (v < OUT_MIN) v = OUT_MIN;
    return v;
  endfunction

  function automatic int clamp_shift(input int s);
    return (s >= IN_W) ? IN_W - 1 : s;
  endfunction

  // Monitor: scoreboard on outputs, hold checks while stalled, shift tracking.
  initial begin
    bit     stall_prev = 0;
    longint hold_val = 0;
    int     hold_ch = 0;
    longint e;
    int     ec;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_val_q.delete();
        exp_ch_q.delete();
        model_shift = RST_SH;
        stall_prev  = 0;
      end else begin
        check_eq("shift_o", shift_o, model_shift);
        if (stall_prev) begin
          check_eq("hold_valid", out_valid, 1);
          check_eq("hold_data", longint'($signed(feedback_o)), hold_val);
          check_eq("hold_ch", out_ch, hold_ch);
        end
        if (out_valid && out_ready) begin
          if (exp_val_q.size() == 0) begin
            check_eq("spurious_out", out_valid, 0);
          end else begin
            e  = exp_val_q.pop_front();
            ec = exp_ch_q.pop_front();
            $display("out ch=%0d data=%0d exp=%0d", out_ch, $signed(feedback_o), e);
            check_eq("out_data", longint'($signed(feedback_o)), e);
            check_eq("out_ch", out_ch, ec);
          end
        end
        stall_prev = out_valid && !out_ready;
        hold_val   = longint'($signed(feedback_o));
        hold_ch    = out_ch;
        if (in_valid && in_ready) begin
          exp_val_q.push_back(model_out(feedback_i, model_shift));
          exp_ch_q.push_back(in_ch);
        end
        if (cfg_we) model_shift = clamp_shift(cfg_shift);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] x, input logic ch);
    bit ok;
    ok = 0;
    in_valid = 1'b1;
    feedback_i = x;
    in_ch = ch;
    for (int i = 0; i < 50 && !ok; i++) begin
      ok = in_ready;
      tick();
    end
    in_valid = 1'b0;
    if (!ok) check_eq("send_timeout", ok, 1);
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int i = 0; i < 50 && exp_val_q.size() != 0; i++) tick();
    tick();
    check_eq("drain_empty", exp_val_q.size(), 0);
  endtask

  initial begin
    logic [31:0] vals [3];
    int idx;
    bit acc;
    int mode;

    // Reset
    repeat (3) tick();
    rst_n = 1'b1;
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_feedback_o", feedback_o, 0);
    check_eq("rst_out_ch", out_ch, 0);
    check_eq("rst_sat_flag", sat_flag, 0);
    check_eq("rst_shift_o", shift_o, RST_SH);
    check_eq("rst_in_ready", in_ready, 1);

    // Latency: 64 >> 6 = 1, valid two cycles after acceptance
    send(32'd64, 1'b0);
    @(negedge clk);
    check_eq("lat_cycle1", out_valid, 0);
    @(negedge clk);
    check_eq("lat_cycle2", out_valid, 1);
    check_eq("lat_data", longint'($signed(feedback_o)), 1);
    check_eq("lat_ch", out_ch, 0);
    tick();
    drain();

    // Rounding vs truncation
    send(-32'sd65, 1'b1);
    send(32'd32, 1'b0);
    drain();

    // Saturation and sticky flags
    send(32'h7FFF_FFFF, 1'b1);
    drain();
    check_eq("sat_flag_ch1", sat_flag, 2'b10);
    send(32'h8000_0000, 1'b0);
    drain();
    check_eq("sat_flag_both", sat_flag, 2'b11);
    sat_clr = 1'b1;
    tick();
    sat_clr = 1'b0;
    check_eq("sat_flag_clr", sat_flag, 2'b00);
    send(32'h8000_0000, 1'b0);
    drain();
    check_eq("sat_flag_ch0", sat_flag, 2'b01);
    send(32'h7FFF_FFFF, 1'b1);
    sat_clr = 1'b1;
    tick();
    sat_clr = 1'b0;
    check_eq("sat_clr_vs_set", sat_flag, 2'b10);
    drain();

    // Backpressure: three back-to-back samples while out_ready is low
    vals[0] = 32'd1000; vals[1] = -32'sd3000; vals[2] = 32'd7777;
    out_ready = 1'b0;
    idx = 0;
    for (int c = 0; c < 4; c++) begin
      in_valid = (idx < 3);
      feedback_i = vals[idx];
      in_ch = idx[0];
      if (c >= 2) check_eq("stall_in_ready", in_ready, 0);
      acc = in_ready && in_valid;
      tick();
      if (acc) idx++;
    end
    check_eq("stall_accepted", idx, 2);
    out_ready = 1'b1;
    for (int c = 0; c < 20 && idx < 3; c++) begin
      in_valid = 1'b1;
      feedback_i = vals[idx];
      in_ch = idx[0];
      acc = in_ready;
      tick();
      if (acc) idx++;
    end
    in_valid = 1'b0;
    check_eq("stall_all_sent", idx, 3);
    drain();

    // Shift update coincident with acceptance: A uses old shift, B the new one
    cfg_we = 1'b1;
    cfg_shift = 6'd0;
    send(32'd256, 1'b0);
    cfg_we = 1'b0;
    check_eq("cfg_shift0", shift_o, 0);
    send(32'd256, 1'b1);
    drain();
    cfg_we = 1'b1;
    cfg_shift = 6'd40;
    tick();
    cfg_we = 1'b0;
    check_eq("cfg_shift_clamp", shift_o, 31);

    // Reset with two samples in flight
    out_ready = 1'b0;
    send(32'h4000_0000, 1'b0);
    send(32'hC000_0000, 1'b1);
    check_eq("pre_rst_valid", out_valid, 1);
    rst_n = 1'b0;
    #1;
    check_eq("midrst_out_valid", out_valid, 0);
    check_eq("midrst_shift_o", shift_o, RST_SH);
    tick();
    tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    check_eq("post_rst_in_ready", in_ready, 1);
    repeat (5) tick();
    check_eq("post_rst_no_output", out_valid, 0);

    // Randomized traffic
    for (int c = 0; c < 400; c++) begin
      in_valid = 1'($urandom_range(0, 1));
      mode = $urandom_range(0, 3);
      case (mode)
        0: feedback_i = $urandom();
        1: feedback_i = 32'($urandom_range(0, 4000)) - 32'd2000;
        2: feedback_i = $urandom_range(0, 1) ? 32'h7FFF_FFFF : 32'h8000_0000;
        default: feedback_i = 32'($urandom_range(0, 1 << 20)) - 32'd524288;
      endcase
      in_ch = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 9) < 7);
      cfg_we = ($urandom_range(0, 9) == 0);
      cfg_shift = 6'($urandom_range(0, 63));
      sat_clr = ($urandom_range(0, 15) == 0);
      tick();
    end
    in_valid = 1'b0;
    cfg_we = 1'b0;
    sat_clr = 1'b0;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/pi_feedback_scaler.md
# pi_feedback_scaler

Programmable feedback gain stage for the PI loop: scales each signed feedback sample by a run-time arithmetic right shift, with optional round-to-nearest, saturates to the output width and tags samples with a channel index. It supersedes the fixed shift-by-6 feedback path. It sits between the PI controller output and the drive/DAC path as a 2-stage valid/ready pipeline.

## Interface
- IN_W, 32, input sample width (signed); must be ≥ OUT_W
- OUT_W, 32, output sample width (signed)
- SHIFT_W, 5, width of the gain-shift field
- N_CH, 2, number of channels multiplexed on the stream; CH_W = max(1, clog2(N_CH))
- RST_SHIFT, 6, shift value loaded at reset
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input sample valid
- in_ready  out  1  stage can accept input this cycle
- in_ch  in  CH_W  channel tag of input sample
- feedback_i  in  IN_W  signed input sample
- out_valid  out  1  output sample valid
- out_ready  in  1  downstream accepts output
- out_ch  out  CH_W  channel tag of output sample
- feedback_o  out  OUT_W  signed scaled, saturated sample
- cfg_we  in  1  write strobe for cfg_shift
- cfg_shift  in  SHIFT_W  new gain shift
- shift_o  out  SHIFT_W  currently active shift value
- sat_clr  in  1  clear all sticky saturation flags
- sat_flag  out  N_CH  per-channel sticky saturation flag

## Operation
- Transfer occurs on a cycle where valid && ready; feedback_i and in_ch are sampled only then.
- Shift register: on cfg_we, shift_o <= cfg_shift. Values ≥ IN_W are clamped to IN_W-1 on write.
- Each sample captures shift_o at acceptance. If cfg_we and acceptance coincide, that sample uses the old shift; the new value applies from the next accepted sample. In-flight samples are never rescaled.
- Stage 1: sign-extend to IN_W+1 bits, add rounding term (see Configuration), arithmetic right shift by the captured s. Shift 0 passes through unchanged.
- Stage 2: if the stage-1 result is > 2^(OUT_W-1)-1 or < -2^(OUT_W-1), clamp to that bound and set sat_flag[ch]; otherwise truncate to OUT_W bits (lossless). With OUT_W = IN_W, no clamping ever occurs.
- sat_flag is sticky. sat_clr clears all bits. A saturation event in the same cycle as sat_clr wins: the bit is set.
- Channel tag travels with the sample unchanged; in_ch ≥ N_CH is passed through, and its saturation event is dropped.
- Pipeline: stage 2 loads when it is empty or out_ready=1; stage 1 loads when it is empty or stage 2 loads. in_ready = !s1_valid || s1_advance (combinational from out_ready). No sample is dropped, duplicated or reordered.
- out_valid, once high, holds with feedback_o and out_ch stable until out_ready.

## Timing
- Latency: 2 cycles from input acceptance to out_valid, with no stall; throughput 1 sample/cycle.
- Up to 2 samples buffered; in_ready falls only when both stages are full and out_ready=0.
- Reset (async assert, sync release inside the block is not required): out_valid=0, feedback_o=0, out_ch=0, sat_flag=0, shift_o=RST_SHIFT; in_ready=1 in the first cycle after reset.
- Reset mid-operation discards both in-flight samples; no output after release until new input.
- cfg_we takes effect on shift_o one cycle after the strobe.

## Configuration
- FEEDBACK_ROUND_EN defined: for s>0, add 2^(s-1) before shifting (round half toward +inf).
- Not defined: no rounding term (floor / truncation toward -inf, same as the legacy path).
- Saturation, tagging and the handshake are identical in both builds.

## Test plan
- Reset, IN_W=32, OUT_W=16, in 64 on ch0, out_ready=1 -> out 1, ch0 valid exactly 2 cycles after accept, shift_o=6.
- Input -65, shift 6 -> output -1 with FEEDBACK_ROUND_EN, -2 without; input 32 -> 1 rounded, 0 truncated.
- Input 0x7FFF_FFFF on ch1, shift 6 -> 32767, sat_flag=2'b10; 0x8000_0000 on ch0 -> -32768, flag=2'b11; sat_clr -> 0; sat_clr coincident with new saturation -> that bit set.
- out_ready=0 for 4 cycles while 3 samples are offered back-to-back -> in_ready low after 2 accepted, all 3 emerge in order, held stable while stalled.
- cfg_we with cfg_shift=0 in the accept cycle of sample A=256 and then B=256 -> A out 4, B out 256 (saturation with OUT_W=16 is not hit); cfg_shift=40 -> shift_o=31.
- Assert rst_n with 2 samples in flight -> out_valid=0 immediately, no spurious output after release, shift_o back to 6.
